// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer: buffer sizing defaults,
// exception flag positions, cause codes and the stored entry layout.
package inst_buffer_pkg;

    localparam int unsigned IB_DEPTH = 8;
    localparam int unsigned IB_AFULL = 6;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned EXC_W   = 3;
    localparam int unsigned CAUSE_W = 7;

    // Bit positions inside is_exception = {decoder, instbuffer, pc}
    localparam int unsigned EXC_BIT_DECODER    = 2;
    localparam int unsigned EXC_BIT_INSTBUFFER = 1;
    localparam int unsigned EXC_BIT_PC         = 0;

    localparam logic [CAUSE_W-1:0] EXCEPTION_INE = 7'h0D;

    // 74-bit buffered fetch entry
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    inst;
        logic [EXC_W-1:0]   is_exception;
        logic [CAUSE_W-1:0] cause;
    } ib_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side and decode-side signal bundle of the instruction buffer.
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    logic               flush;
    logic               fetch_valid;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    fetch_inst;
    logic [EXC_W-1:0]   fetch_is_exception;
    logic [CAUSE_W-1:0] fetch_pc_exception_cause;
    logic               fetch_stall;
    logic               decode_ready;
    logic               out_valid;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_inst;
    logic [EXC_W-1:0]   out_is_exception;
    logic [CAUSE_W-1:0] out_pc_exception_cause;
    logic [CAUSE_W-1:0] out_instbuffer_exception_cause;

    modport master (
        output flush, fetch_valid, fetch_pc, fetch_inst, fetch_is_exception,
               fetch_pc_exception_cause, decode_ready,
        input  fetch_stall, out_valid, out_pc, out_inst, out_is_exception,
               out_pc_exception_cause, out_instbuffer_exception_cause
    );

    modport slave (
        input  flush, fetch_valid, fetch_pc, fetch_inst, fetch_is_exception,
               fetch_pc_exception_cause, decode_ready,
        output fetch_stall, out_valid, out_pc, out_inst, out_is_exception,
               out_pc_exception_cause, out_instbuffer_exception_cause
    );

endinterface

// File: rtl/inst_buffer.sv
// First-word fall-through instruction buffer between fetch and decode,
// with almost-full fetch stall and single-cycle flush.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = IB_DEPTH,
    parameter int unsigned AFULL_LEVEL = IB_AFULL
) (
    input  logic          clk,
    input  logic          rst,
    inst_buffer_if.slave  ib
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    ib_entry_t        mem [DEPTH];
    ib_entry_t        head;
    ib_entry_t        wr_entry;
    logic             push;
    logic             pop;
    logic             not_empty;

    assign not_empty = (count != '0);
    assign push      = ib.fetch_valid && (count < CNT_W'(DEPTH)) && !ib.flush;
    assign pop       = not_empty && ib.decode_ready && !ib.flush;

    assign wr_entry = '{
        pc:           ib.fetch_pc,
        inst:         ib.fetch_inst,
        is_exception: ib.fetch_is_exception,
        cause:        ib.fetch_pc_exception_cause
    };

    // Storage is left unreset; it is only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping; flush outranks push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ib.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

    // Head entry falls through combinationally and reads as zero when empty
    always_comb begin
        ib.out_valid              = not_empty;
        ib.out_pc                 = '0;
        ib.out_inst               = '0;
        ib.out_is_exception       = '0;
        ib.out_pc_exception_cause = '0;
        if (not_empty) begin
            ib.out_pc                 = head.pc;
            ib.out_inst               = head.inst;
            ib.out_is_exception       = head.is_exception;
            ib.out_pc_exception_cause = head.cause;
        end
    end

    assign ib.fetch_stall                    = (count >= CNT_W'(AFULL_LEVEL));
    assign ib.out_instbuffer_exception_cause = EXCEPTION_INE;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed testbench for inst_buffer: vector table plus hand-written
// sequences for fill/stall, streaming wrap, flush and asynchronous reset.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_buffer_if ibif ();

    inst_buffer #(.DEPTH(8), .AFULL_LEVEL(6)) dut (
        .clk (clk),
        .rst (rst),
        .ib  (ibif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  exc;
        logic [6:0]  cause;
        logic        dr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_exc;
        logic [6:0]  e_cause;
        logic        e_stall;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
    task automatic step(input logic fl, input logic fv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic [2:0] exc,
                        input logic [6:0] cause, input logic dr);
        @(negedge clk);
        ibif.flush                    = fl;
        ibif.fetch_valid              = fv;
        ibif.fetch_pc                 = pc;
        ibif.fetch_inst               = inst;
        ibif.fetch_is_exception       = exc;
        ibif.fetch_pc_exception_cause = cause;
        ibif.decode_ready             = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ibif.flush                    = 1'b0;
        ibif.fetch_valid              = 1'b0;
        ibif.fetch_pc                 = '0;
        ibif.fetch_inst               = '0;
        ibif.fetch_is_exception       = '0;
        ibif.fetch_pc_exception_cause = '0;
        ibif.decode_ready             = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] pc;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();

        //                 fl  fv  pc            inst          exc     cause  dr   ev  epc           einst         eexc    ecause stall
        vecs[0]  = '{1'b0,1'b1,32'h1C000000,32'h02800C21,3'b000,7'h00,1'b0,1'b1,32'h1C000000,32'h02800C21,3'b000,7'h00,1'b0};
        vecs[1]  = '{1'b0,1'b1,32'h1C000004,32'hAAAA0004,3'b000,7'h00,1'b0,1'b1,32'h1C000000,32'h02800C21,3'b000,7'h00,1'b0};
        vecs[2]  = '{1'b0,1'b1,32'h1C000008,32'hAAAA0008,3'b000,7'h00,1'b1,1'b1,32'h1C000004,32'hAAAA0004,3'b000,7'h00,1'b0};
        vecs[3]  = '{1'b0,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b1,1'b1,32'h1C000008,32'hAAAA0008,3'b000,7'h00,1'b0};
        vecs[4]  = '{1'b0,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b1,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b0};
        vecs[5]  = '{1'b0,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b1,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b0};
        vecs[6]  = '{1'b0,1'b1,32'h1C00000C,32'h12345678,3'b001,7'h08,1'b0,1'b1,32'h1C00000C,32'h12345678,3'b001,7'h08,1'b0};
        vecs[7]  = '{1'b0,1'b1,32'h1C000010,32'h9ABCDEF0,3'b010,7'h15,1'b0,1'b1,32'h1C00000C,32'h12345678,3'b001,7'h08,1'b0};
        vecs[8]  = '{1'b0,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b1,1'b1,32'h1C000010,32'h9ABCDEF0,3'b010,7'h15,1'b0};
        vecs[9]  = '{1'b1,1'b1,32'h1C000014,32'h11111111,3'b000,7'h00,1'b1,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b0};
        vecs[10] = '{1'b0,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b0,1'b0,32'h00000000,32'h00000000,3'b000,7'h00,1'b0};

        // Reset state while rst is held
        #12;
        chk("rst_valid", 32'(ibif.out_valid), 32'h0);
        chk("rst_stall", 32'(ibif.fetch_stall), 32'h0);
        chk("rst_pc", ibif.out_pc, 32'h0);
        chk("rst_inst", ibif.out_inst, 32'h0);
        chk("rst_exc", 32'(ibif.out_is_exception), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].flush, vecs[i].fv, vecs[i].pc, vecs[i].inst, vecs[i].exc,
                 vecs[i].cause, vecs[i].dr);
            chk($sformatf("v%0d_valid", i), 32'(ibif.out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_pc", i), ibif.out_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_inst", i), ibif.out_inst, vecs[i].e_inst);
            chk($sformatf("v%0d_exc", i), 32'(ibif.out_is_exception), 32'(vecs[i].e_exc));
            chk($sformatf("v%0d_stall", i), 32'(ibif.fetch_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_ibcause", i), 32'(ibif.out_instbuffer_exception_cause),
                32'(EXCEPTION_INE));
            if (vecs[i].e_valid)
                chk($sformatf("v%0d_cause", i), 32'(ibif.out_pc_exception_cause),
                    32'(vecs[i].e_cause));
        end

        // Fill to full with decode stalled; stall asserts at occupancy 6
        do_reset();
        base = 32'h1C000000;
        for (int k = 1; k <= 8; k++) begin
            pc = base + 32'(4 * (k - 1));
            step(1'b0, 1'b1, pc, ~pc, 3'b000, 7'h00, 1'b0);
            chk($sformatf("fill%0d_stall", k), 32'(ibif.fetch_stall), (k >= 6) ? 32'h1 : 32'h0);
            chk($sformatf("fill%0d_head", k), ibif.out_pc, base);
        end
        // 9th push while full is dropped
        step(1'b0, 1'b1, 32'h1C000020, 32'hDEADBEEF, 3'b000, 7'h00, 1'b0);
        chk("full_drop_head", ibif.out_pc, base);
        chk("full_drop_stall", 32'(ibif.fetch_stall), 32'h1);
        // Push and pop together at full: only the pop happens
        step(1'b0, 1'b1, 32'h1C000024, 32'hDEADBEEF, 3'b000, 7'h00, 1'b1);
        chk("full_pp_head", ibif.out_pc, base + 32'h4);
        chk("full_pp_stall", 32'(ibif.fetch_stall), 32'h1);
        // Drain the remaining seven entries in order
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("drain%0d_pc", k), ibif.out_pc, base + 32'(4 * k));
            chk($sformatf("drain%0d_inst", k), ibif.out_inst, ~(base + 32'(4 * k)));
            step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 7'h00, 1'b1);
            chk($sformatf("drain%0d_stall", k), 32'(ibif.fetch_stall),
                ((7 - k) >= 6) ? 32'h1 : 32'h0);
        end
        chk("drain_empty", 32'(ibif.out_valid), 32'h0);

        // Streaming push+pop for 20 cycles keeps occupancy at 1 across wraps
        do_reset();
        base = 32'h1C001000;
        step(1'b0, 1'b1, base, 32'h55550000, 3'b000, 7'h00, 1'b0);
        for (int j = 1; j <= 20; j++) begin
            pc = base + 32'(4 * j);
            step(1'b0, 1'b1, pc, 32'h55550000 + 32'(j), 3'b000, 7'h00, 1'b1);
            chk($sformatf("stream%0d_pc", j), ibif.out_pc, pc);
            chk($sformatf("stream%0d_inst", j), ibif.out_inst, 32'h55550000 + 32'(j));
            chk($sformatf("stream%0d_valid", j), 32'(ibif.out_valid), 32'h1);
            chk($sformatf("stream%0d_stall", j), 32'(ibif.fetch_stall), 32'h0);
        end
        // Exactly one entry remains
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 7'h00, 1'b1);
        chk("stream_empty", 32'(ibif.out_valid), 32'h0);

        // Flush with count 5 while fetch and decode are both active
        do_reset();
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b1, 32'h1C002000 + 32'(4 * k), 32'h0, 3'b000, 7'h00, 1'b0);
        chk("preflush_stall", 32'(ibif.fetch_stall), 32'h0);
        chk("preflush_head", ibif.out_pc, 32'h1C002000);
        step(1'b1, 1'b1, 32'h1C003000, 32'h0, 3'b000, 7'h00, 1'b1);
        chk("flush_valid", 32'(ibif.out_valid), 32'h0);
        chk("flush_stall", 32'(ibif.fetch_stall), 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 7'h00, 1'b0);
        chk("postflush_valid", 32'(ibif.out_valid), 32'h0);

        // Asynchronous reset between edges with 3 entries held
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 32'h1C004000 + 32'(4 * k), 32'h0, 3'b000, 7'h00, 1'b0);
        chk("prerst_valid", 32'(ibif.out_valid), 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ibif.out_valid), 32'h0);
        chk("arst_pc", ibif.out_pc, 32'h0);
        chk("arst_stall", 32'(ibif.fetch_stall), 32'h0);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 32'h1C005000, 32'h02800C21, 3'b000, 7'h00, 1'b0);
        chk("postrst_valid", 32'(ibif.out_valid), 32'h1);
        chk("postrst_pc", ibif.out_pc, 32'h1C005000);
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 7'h00, 1'b1);
        chk("postrst_empty", 32'(ibif.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
